// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the line memory responder.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_resp_pkg;

   localparam int LINE_W = 128;
   localparam int ADDR_W = 28;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2,
      GAP  = 2'd3
   } state_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_t;

endpackage

// File: rtl/mem_line_array.sv
// Line storage: DEPTH x LINE_W, one write port and one registered read port.
// Latency: write lands on the clock edge; read data appears one edge after re.
// Backpressure: none; the port is always able to accept a read and a write.
// Ports: clk/rst (async active-high, clears every line and rdata),
//        we/widx/wdata write port, re/ridx read request, rdata held read data.
module mem_line_array
   import mem_resp_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [IDX_W-1:0]  widx,
   input  logic [LINE_W-1:0] wdata,
   input  logic              re,
   input  logic [IDX_W-1:0]  ridx,
   output logic [LINE_W-1:0] rdata
);

   logic [LINE_W-1:0] line_q [DEPTH];
   logic [LINE_W-1:0] rdata_q, rdata_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
      end else if (we) begin
         line_q[widx] <= wdata;
      end
   end

   // Read data holds its last value until the next read request.
   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = line_q[ridx];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Line memory responder: answers each read/write with a one-cycle mem_ready pulse.
// Latency: mem_ready LATENCY cycles after the request is first seen in IDLE; LATENCY+2 cycles per transaction.
// Backpressure: initiator holds the request until mem_ready; requests are ignored outside IDLE.
// Ports: clk, proc_reset (async active-high); mem_read/mem_write/mem_addr/mem_wdata request in;
//        mem_rdata/mem_ready response out; proto_err sticky protocol flag.
// Optional: define MEM_RESP_CHECK_EN to build the protocol checker; otherwise proto_err is 0.
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              proc_reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [LINE_W-1:0] mem_wdata,
   output logic [LINE_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              proto_err
);

   localparam int          IDX_W    = $clog2(DEPTH);
   localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);

   state_t             state_q, state_d;
   op_t                op_q, op_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [LINE_W-1:0]  wdata_q, wdata_d;
   logic [7:0]         cnt_q, cnt_d;

   logic               req;
   op_t                req_op;
   logic               arr_we, arr_re;
   logic               unused_addr_hi;

   assign req    = mem_read | mem_write;
   // Both strobes high resolves to a write.
   assign req_op = mem_write ? OP_WRITE : OP_READ;
   // Upper address bits only alias; they select nothing.
   assign unused_addr_hi = ^mem_addr[ADDR_W-1:IDX_W];

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               op_d    = req_op;
               idx_d   = mem_addr[IDX_W-1:0];
               wdata_d = mem_wdata;
               cnt_d   = CNT_LOAD;
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            // Leave as the count reaches zero, so WAIT lasts LATENCY-1 cycles.
            cnt_d = cnt_q - 8'd1;
            if (cnt_d == 8'd0) state_d = RESP;
         end
         RESP:    state_d = GAP;
         default: state_d = IDLE;
      endcase
   end

   // Read data is captured on the edge that enters RESP; writes commit as RESP ends.
   assign arr_re    = (state_d == RESP) && (op_d == OP_READ) && (state_q != RESP);
   assign arr_we    = (state_q == RESP) && (op_q == OP_WRITE);
   assign mem_ready = (state_q == RESP);

   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         state_q <= IDLE;
         op_q    <= OP_READ;
         idx_q   <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
      end
   end

   mem_line_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .rst   (proc_reset),
      .we    (arr_we),
      .widx  (idx_q),
      .wdata (wdata_q),
      .re    (arr_re),
      .ridx  (idx_d),
      .rdata (mem_rdata)
   );

`ifdef MEM_RESP_CHECK_EN
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        gap_age_q, gap_age_d;   // 1 = first IDLE cycle after GAP, 2 = second
   logic              proto_err_q, proto_err_d;
   logic              viol;

   always_comb begin
      addr_d = addr_q;
      if (state_q == IDLE && req) addr_d = mem_addr;

      gap_age_d = 2'd0;
      if (state_q == GAP)                             gap_age_d = 2'd1;
      else if (state_q == IDLE && gap_age_q == 2'd1)  gap_age_d = 2'd2;

      viol = 1'b0;
      if (mem_read && mem_write) viol = 1'b1;
      if (state_q == WAIT || state_q == RESP) begin
         if (!req || req_op != op_q || mem_addr != addr_q) viol = 1'b1;
         if (op_q == OP_WRITE && mem_wdata != wdata_q)     viol = 1'b1;
      end
      if (state_q == IDLE && gap_age_q == 2'd2 && req) viol = 1'b1;

      proto_err_d = proto_err_q | viol;
   end

   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         addr_q      <= '0;
         gap_age_q   <= 2'd0;
         proto_err_q <= 1'b0;
      end else begin
         addr_q      <= addr_d;
         gap_age_q   <= gap_age_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign proto_err = proto_err_q;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!proc_reset && viol) $display("mem_responder: protocol violation at %0t", $time);
   end
`endif
`else
   assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: stimulus pushes expected responses, a negedge monitor compares.
module tb_mem_responder;
   import mem_resp_pkg::*;

   logic              clk = 1'b0;
   logic              proc_reset;
   logic              mem_read, mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_ready;
   logic              proto_err;

   mem_responder #(.DEPTH(64), .LATENCY(4)) dut (
      .clk        (clk),
      .proc_reset (proc_reset),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .proto_err  (proto_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   logic [LINE_W-1:0] exp_dat_q [$];
   int                exp_cyc_q [$];
   logic [LINE_W-1:0] mon_d;
   int                mon_c;

   localparam logic [LINE_W-1:0] D1 = 128'hDEADBEEF_00000001_CAFEF00D_12345678;

`ifdef MEM_RESP_CHECK_EN
   localparam logic PE_EXP = 1'b1;
`else
   localparam logic PE_EXP = 1'b0;
`endif

   task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Every mem_ready cycle must match the next queued response (data and cycle).
   always @(negedge clk) begin
      if (!proc_reset && mem_ready) begin
         if (exp_dat_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ready: response at cycle %0d, want none", cyc);
         end else begin
            mon_d = exp_dat_q.pop_front();
            mon_c = exp_cyc_q.pop_front();
            check("rdata", mem_rdata, mon_d);
            check("ready_cycle", 128'(cyc), 128'(mon_c));
         end
      end
   end

   task automatic wait_ready(input string name);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!mem_ready && n < 20);
      if (!mem_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: no mem_ready within 20 cycles, want a pulse", name);
      end
   endtask

   // Issue one request 'idle' cycles after the previous drop, hold to RESP, drop in GAP.
   task automatic txn(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                      input logic [LINE_W-1:0] wdat, input logic [LINE_W-1:0] exp, input int idle);
      repeat (idle) @(posedge clk);
      #1;
      mem_read  = rd;
      mem_write = wr;
      mem_addr  = addr;
      mem_wdata = wdat;
      exp_dat_q.push_back(exp);
      exp_cyc_q.push_back(cyc + 4);
      wait_ready("txn_ready");
      @(posedge clk); #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      proc_reset = 1'b1;
      @(posedge clk); #1;
      proc_reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      proc_reset = 1'b1;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_ready", 128'(mem_ready), 128'd0);
      check("reset_rdata", mem_rdata, 128'd0);
      check("reset_proto_err", 128'(proto_err), 128'd0);
      proc_reset = 1'b0;

      // Read of never-written line, then write/read-back, then alias through index 3.
      txn(1'b1, 1'b0, 28'h0000005, '0, 128'h0, 2);
      txn(1'b0, 1'b1, 28'h0000003, D1, 128'h0, 4);
      txn(1'b1, 1'b0, 28'h0000003, '0, D1, 4);
      txn(1'b0, 1'b1, 28'h0000043, 128'h1, D1, 4);
      txn(1'b1, 1'b0, 28'h0000003, '0, 128'h1, 4);

      // Back-to-back: reasserted in the first IDLE cycle after GAP, pulses 6 apart.
      txn(1'b1, 1'b0, 28'h0000003, '0, 128'h1, 4);
      txn(1'b1, 1'b0, 28'h0000005, '0, 128'h0, 1);
      txn(1'b1, 1'b0, 28'h0000043, '0, 128'h1, 1);
      @(posedge clk); #1;
      check("rdata_hold", mem_rdata, 128'h1);

      // Both strobes high behaves as a write.
      txn(1'b1, 1'b1, 28'h0000009, 128'hA5, 128'h1, 4);
      txn(1'b1, 1'b0, 28'h0000009, '0, 128'hA5, 4);

      // Reset in RESP: mem_ready drops without waiting for a clock.
      repeat (4) @(posedge clk);
      #1;
      mem_read = 1'b1;
      mem_addr = 28'h0000009;
      wait_ready("resp_reset_ready");
      check("resp_before_reset", mem_rdata, 128'hA5);
      proc_reset = 1'b1;
      #1;
      check("ready_async_drop", 128'(mem_ready), 128'd0);
      check("rdata_after_reset", mem_rdata, 128'h0);
      mem_read = 1'b0;
      @(posedge clk); #1;
      proc_reset = 1'b0;

      // Reset two cycles into WAIT of a write to index 7: the write is dropped.
      repeat (4) @(posedge clk);
      #1;
      mem_write = 1'b1;
      mem_addr  = 28'h0000007;
      mem_wdata = 128'hFF;
      repeat (3) @(posedge clk);
      #1;
      proc_reset = 1'b1;
      #1;
      check("wait_reset_ready", 128'(mem_ready), 128'd0);
      mem_write = 1'b0;
      mem_wdata = '0;
      @(posedge clk); #1;
      proc_reset = 1'b0;
      txn(1'b1, 1'b0, 28'h0000007, '0, 128'h0, 4);

      // Address change during WAIT.
      pulse_reset();
      check("proto_err_cleared", 128'(proto_err), 128'd0);
      repeat (4) @(posedge clk);
      #1;
      mem_read = 1'b1;
      mem_addr = 28'h0000010;
      exp_dat_q.push_back(128'h0);
      exp_cyc_q.push_back(cyc + 4);
      repeat (2) @(posedge clk);
      #1;
      mem_addr = 28'h0000011;
      wait_ready("proto_ready");
      @(posedge clk); #1;
      mem_read = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("proto_err_set", 128'(proto_err), 128'(PE_EXP));
      repeat (5) @(posedge clk);
      #1;
      check("proto_err_sticky", 128'(proto_err), 128'(PE_EXP));
      pulse_reset();
      check("proto_err_reset", 128'(proto_err), 128'd0);

      repeat (3) @(posedge clk);
      #1;
      check("responses_outstanding", 128'(exp_dat_q.size()), 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the 128-bit line memory interface that the cache hierarchy drives as initiator (mem_read/mem_write/mem_addr/mem_wdata in, mem_rdata/mem_ready out).
- Holds a line-granular storage array and answers each request after a programmable fixed latency with a single-cycle mem_ready pulse.
- Sits below the L2 cache in simulation and FPGA builds, in place of the external memory model.

Parameters:
- DEPTH, 64, number of 128-bit lines stored; must be a power of 2, minimum 2.
- LATENCY, 4, cycles from request acceptance to mem_ready; minimum 1, maximum 255.

Ports:
- clk  in  1  single clock, all state on rising edge.
- proc_reset  in  1  asynchronous, active-high reset.
- mem_read  in  1  line read request; held by the initiator until mem_ready.
- mem_write  in  1  line write request; held by the initiator until mem_ready.
- mem_addr  in  28  line address; stable while a request is held.
- mem_wdata  in  128  write line data; stable while mem_write is held.
- mem_rdata  out  128  read line data; valid in the mem_ready cycle of a read.
- mem_ready  out  1  one-cycle completion pulse.
- proto_err  out  1  sticky protocol-violation flag; tied 0 unless MEM_RESP_CHECK_EN is defined.

Behaviour:
- Reset (async assert, sync release): state IDLE, mem_ready=0, mem_rdata=0, latency counter=0, proto_err=0, every storage line=0.
- Index = mem_addr[log2(DEPTH)-1:0]. Upper address bits are ignored, so addresses alias modulo DEPTH.
- FSM states: IDLE, WAIT, RESP, GAP.
  - IDLE: if mem_read or mem_write is high, latch op, index and wdata, load counter=LATENCY-1, go WAIT. If LATENCY=1, go directly to RESP.
  - WAIT: decrement counter each cycle; at 0 go RESP. The latched request is used, so input changes during WAIT have no effect.
  - RESP: mem_ready=1 for exactly this cycle.
    - Read: mem_rdata = storage[index], registered on the RESP entry edge.
    - Write: storage[index] <= latched wdata at the end of RESP; mem_rdata keeps its previous value.
    - Next state is GAP.
  - GAP: one cycle, requests ignored (the initiator drops its request in this cycle), then IDLE.
- Timing: request first seen high in IDLE at edge 0 produces mem_ready high in the cycle after edge LATENCY. The minimum spacing between back-to-back transactions is LATENCY+2 cycles.
- mem_rdata holds its last read value outside RESP.
- mem_read and mem_write both high in IDLE: treated as a write.
- Read-after-write to the same index: the next transaction observes the written data, because the write commits before GAP.
- Reset during WAIT or RESP: the transaction is abandoned and any pending write is dropped. mem_ready falls immediately (asynchronously).

Optional Feature:
- Macro: MEM_RESP_CHECK_EN.
- Defined: proto_err sets and stays set until reset when any of the following occurs:
  - mem_read and mem_write are both high in any cycle;
  - during WAIT or RESP, the request drops, the op changes, mem_addr changes, or mem_wdata changes on a write;
  - a request is still high in the second cycle of IDLE after GAP (i.e. the initiator failed to drop it).
  - Under simulation, each violation also prints a $display with the cycle time.
- Not defined: no checker logic is built and proto_err is constant 0.

Decomposition:
- Package mem_resp_pkg holds:
  - LINE_W=128 and ADDR_W=28;
  - the state typedef (IDLE/WAIT/RESP/GAP, 2-bit encoding);
  - the op typedef (OP_READ/OP_WRITE).
- One sub-module, mem_line_array: DEPTH x LINE_W storage with async-reset-to-zero, one write port (we, widx, wdata) and one registered read port (re, ridx, rdata).
- The FSM, latency counter and checker live in mem_responder.

Test Plan:
- Reset, then read addr 0x0000005 with LATENCY=4 -> mem_ready high in exactly one cycle, 4 cycles after acceptance; mem_rdata = 128'h0.
- Write addr 0x0000003 with data 128'hDEADBEEF_00000001_CAFEF00D_12345678, then read addr 0x0000003 -> write's mem_ready pulses once; the read returns the same 128-bit value.
- Write addr 0x0000043 (aliases index 3 at DEPTH=64) with 128'h1, then read addr 0x0000003 -> returns 128'h1.
- Back-to-back reads with the request reasserted in the cycle after GAP -> consecutive mem_ready pulses exactly LATENCY+2=6 cycles apart; no double response.
- Assert proc_reset 2 cycles into the WAIT of a write of 128'hFF to index 7, then read index 7 -> mem_ready drops immediately; the read returns 128'h0.
- With MEM_RESP_CHECK_EN: change mem_addr from 0x10 to 0x11 during WAIT -> proto_err goes to 1 and stays 1 until proc_reset; without the macro, proto_err stays 0.
